// File: rtl/piano_notes_pkg.sv
// Piano note constants shared by the pitch detector: nominal periods, bin bounds
// and small arithmetic helpers.
package piano_notes_pkg;

  localparam int NOTE_COUNT = 10;
  localparam int PERIOD_W   = 20;

  typedef logic [NOTE_COUNT-1:0] note_t;

  typedef enum logic [0:0] {
    ARM_LOW   = 1'b0,
    WAIT_HIGH = 1'b1
  } xing_state_e;

  // Nominal periods in CLOCK_50 cycles, C4 first, matching SW[9:0] order.
  localparam logic [PERIOD_W-1:0] NOTE_PERIOD [NOTE_COUNT] = '{
    20'd191110, 20'd170266, 20'd151686, 20'd143174, 20'd127552,
    20'd113638, 20'd101242, 20'd95558,  20'd85138,  20'd75846
  };

  // Note i occupies [BIN_BOUND[i+1], BIN_BOUND[i]).
  localparam logic [PERIOD_W-1:0] BIN_BOUND [NOTE_COUNT+1] = '{
    20'd202000, 20'd180688, 20'd160976, 20'd147430, 20'd135363, 20'd120595,
    20'd107440, 20'd98400,  20'd90348,  20'd80492,  20'd71000
  };

  function automatic note_t classify_period(input logic [PERIOD_W-1:0] p);
    note_t r;
    r = {NOTE_COUNT{1'b0}};
    for (int i = 0; i < NOTE_COUNT; i++) begin
      if ((p >= BIN_BOUND[i+1]) && (p < BIN_BOUND[i])) begin
        r[i] = 1'b1;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Magnitude of a signed sample; the most negative code clamps to the largest positive.
  function automatic logic [30:0] abs_sat(input logic [31:0] s);
    logic [31:0] neg;
    neg = 32'd0 - s;
    if (s == 32'h8000_0000) begin
      return 31'h7FFF_FFFF;
    end else if (s[31]) begin
      return neg[30:0];
    end else begin
      return s[30:0];
    end
  endfunction

endpackage

// File: rtl/pitch_period_classifier.sv
// Registered stage mapping a measured crossing period onto a one-hot note bin
// (all zeros when the period falls outside every bin).
module pitch_period_classifier
  import piano_notes_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                period_valid,
  input  logic [PERIOD_W-1:0] period_in,
  output logic                class_valid,
  output note_t               note_class
);

  logic  class_valid_q, class_valid_d;
  note_t note_class_q, note_class_d;

  always_comb begin
    class_valid_d = period_valid;
    note_class_d  = note_class_q;
    if (period_valid) begin
      note_class_d = classify_period(period_in);
    end else begin
      note_class_d = note_class_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      class_valid_q <= 1'b0;
      note_class_q  <= {NOTE_COUNT{1'b0}};
    end else begin
      class_valid_q <= class_valid_d;
      note_class_q  <= note_class_d;
    end
  end

  assign class_valid = class_valid_q;
  assign note_class  = note_class_q;

endmodule

// File: rtl/audio_in_pitch_detector.sv
// Identifies the played piano note (C4..E5) from microphone samples by timing
// hysteretic positive-going zero crossings and filtering the classification.
module audio_in_pitch_detector
  import piano_notes_pkg::*;
#(
  parameter logic [31:0] HYST    = 32'd1_000_000,
  parameter int          STABLE  = 4,
  parameter logic [19:0] TIMEOUT = 20'd202_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  output logic        read_audio_in,
  output logic [9:0]  note_onehot,
  output logic        note_valid,
  output logic [19:0] period,
  output logic [30:0] peak_level
);

  localparam int                  MW       = $clog2(STABLE + 1);
  localparam logic [MW-1:0]       STABLE_M = MW'(STABLE);
  localparam logic signed [32:0]  HYST_POS = $signed({1'b0, HYST});
  localparam logic signed [32:0]  HYST_NEG = -HYST_POS;
  localparam logic [PERIOD_W-1:0] CNT_MAX  = 20'hF_FFFF;

  logic                read_s;
  logic                rise_s;
  logic                silence_s;
  logic signed [32:0]  samp_ext_s;
  logic [30:0]         abs_s;
  logic [30:0]         cur_max_s;
  logic                cls_vld_s;
  note_t               cls_s;

  logic [31:0]         sample_q,  sample_d;
  logic                smp_vld_q, smp_vld_d;
  xing_state_e         state_q,   state_d;
  logic [PERIOD_W-1:0] cnt_q,     cnt_d;
  logic [PERIOD_W-1:0] period_q,  period_d;
  logic [30:0]         run_q,     run_d;
  logic [30:0]         peak_q,    peak_d;
  logic [MW-1:0]       match_q,   match_d;
  note_t               prev_q,    prev_d;
  note_t               onehot_q,  onehot_d;
  logic                valid_q,   valid_d;

  assign read_s        = audio_in_available & ~reset;
  assign read_audio_in = read_s;
  assign samp_ext_s    = $signed({sample_q[31], sample_q});
  assign abs_s         = abs_sat(sample_q);

  always_comb begin
    sample_d  = sample_q;
    smp_vld_d = read_s;
    if (read_s) begin
      sample_d = left_channel_audio_in;
    end else begin
      sample_d = sample_q;
    end
  end

  // Samples inside the hysteresis window never move the crossing FSM.
  always_comb begin
    state_d = state_q;
    rise_s  = 1'b0;
    case (state_q)
      ARM_LOW: begin
        if (smp_vld_q && (samp_ext_s < HYST_NEG)) begin
          state_d = WAIT_HIGH;
        end else begin
          state_d = ARM_LOW;
        end
      end
      WAIT_HIGH: begin
        if (smp_vld_q && (samp_ext_s >= HYST_POS)) begin
          state_d = ARM_LOW;
          rise_s  = 1'b1;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = ARM_LOW;
        rise_s  = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    run_d     = run_q;
    peak_d    = peak_q;
    cur_max_s = run_q;
    if (smp_vld_q && (abs_s > run_q)) begin
      cur_max_s = abs_s;
    end else begin
      cur_max_s = run_q;
    end
    if (rise_s) begin
      cnt_d    = 20'd1;
      period_d = cnt_q;
      peak_d   = cur_max_s;
      run_d    = 31'd0;
    end else begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 20'd1);
      run_d = cur_max_s;
    end
  end

  pitch_period_classifier u_classifier (
    .clk          (CLOCK_50),
    .reset        (reset),
    .period_valid (rise_s),
    .period_in    (cnt_q),
    .class_valid  (cls_vld_s),
    .note_class   (cls_s)
  );

  // A rise in the same cycle blocks the silence clear.
  assign silence_s = (cnt_q >= TIMEOUT) && !rise_s;

  always_comb begin
    match_d  = match_q;
    prev_d   = prev_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    if (silence_s) begin
      match_d  = {MW{1'b0}};
      prev_d   = {NOTE_COUNT{1'b0}};
      onehot_d = {NOTE_COUNT{1'b0}};
      valid_d  = 1'b0;
    end else if (cls_vld_s) begin
      if ((cls_s != {NOTE_COUNT{1'b0}}) && (cls_s == prev_q)) begin
        match_d = (match_q >= STABLE_M) ? STABLE_M : (match_q + MW'(1'b1));
      end else begin
        match_d = (cls_s == {NOTE_COUNT{1'b0}}) ? {MW{1'b0}} : MW'(1'b1);
        valid_d = 1'b0;
      end
      if (match_d == STABLE_M) begin
        onehot_d = cls_s;
        valid_d  = 1'b1;
      end else begin
        onehot_d = onehot_q;
      end
      prev_d = cls_s;
    end else begin
      match_d = match_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sample_q  <= 32'd0;
      smp_vld_q <= 1'b0;
      state_q   <= ARM_LOW;
      cnt_q     <= 20'd0;
      period_q  <= 20'd0;
      run_q     <= 31'd0;
      peak_q    <= 31'd0;
      match_q   <= {MW{1'b0}};
      prev_q    <= {NOTE_COUNT{1'b0}};
      onehot_q  <= {NOTE_COUNT{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      sample_q  <= sample_d;
      smp_vld_q <= smp_vld_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      run_q     <= run_d;
      peak_q    <= peak_d;
      match_q   <= match_d;
      prev_q    <= prev_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
    end
  end

  assign note_onehot = onehot_q;
  assign note_valid  = valid_q;
  assign period      = period_q;
  assign peak_level  = peak_q;

endmodule

// File: tb/tb_audio_in_pitch_detector.sv
// Directed bench for audio_in_pitch_detector: square waves sampled every 1042 clocks.
module tb_audio_in_pitch_detector;

  localparam int SPACING = 1042;
  localparam int HYST_I  = 1000000;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        avail = 1'b0;
  logic [31:0] left = 32'd0;
  logic        read_audio_in;
  logic [9:0]  note_onehot;
  logic        note_valid;
  logic [19:0] period;
  logic [30:0] peak_level;

  audio_in_pitch_detector dut (
    .CLOCK_50              (CLOCK_50),
    .reset                 (reset),
    .audio_in_available    (avail),
    .left_channel_audio_in (left),
    .read_audio_in         (read_audio_in),
    .note_onehot           (note_onehot),
    .note_valid            (note_valid),
    .period                (period),
    .peak_level            (peak_level)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_fail = 0;
  int rd_idx = 0;
  int last_rise_rd = -1;
  int rise_n = 0;
  bit armed = 1'b0;
  bit last_rise = 1'b0;
  logic [19:0] g_p1;
  logic [19:0] r_period [32];
  logic [30:0] r_peak [32];
  logic        r_valid1 [32];
  logic        r_valid2 [32];
  logic [9:0]  r_onehot [32];
  int          r_expp [32];

  task automatic do_reset();
    reset = 1'b1;
    avail = 1'b1;
    left  = 32'd0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    avail = 1'b0;
    armed = 1'b0;
    last_rise_rd = -1;
  endtask

  // One FIFO read, then observation of the +1 and +2 cycle outputs; spans SPACING clocks.
  task automatic read_sample(input logic [31:0] s);
    bit rz;
    avail = 1'b1;
    left  = s;
    @(posedge CLOCK_50);
    #1;
    avail = 1'b0;
    rz = 1'b0;
    if ($signed(s) < -HYST_I) armed = 1'b1;
    else if (($signed(s) >= HYST_I) && armed) begin
      rz = 1'b1;
      armed = 1'b0;
    end
    @(posedge CLOCK_50);
    #1;
    g_p1 = period;
    if (rz) begin
      r_period[rise_n] = period;
      r_peak[rise_n]   = peak_level;
      r_valid1[rise_n] = note_valid;
    end
    @(posedge CLOCK_50);
    #1;
    if (rz) begin
      r_valid2[rise_n] = note_valid;
      r_onehot[rise_n] = note_onehot;
      r_expp[rise_n]   = (last_rise_rd >= 0) ? (rd_idx - last_rise_rd) * SPACING : -1;
      last_rise_rd = rd_idx;
      rise_n++;
    end
    last_rise = rz;
    rd_idx++;
    repeat (SPACING - 3) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wave(input int half, input int amp, input int max_reads, input int stop_rises,
                      output int first_idx);
    int got;
    logic [31:0] s;
    first_idx = rise_n;
    got = 0;
    for (int k = 0; (k < max_reads) && (got < stop_rises); k++) begin
      s = ((((k * SPACING) / half) % 2) == 0) ? amp : -amp;
      read_sample(s);
      if (last_rise) got++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    avail = 1'b1;
    left  = 32'h0123_4567;
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_chk++; if (read_audio_in !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %0d expected 0", read_audio_in); end
    n_chk++; if (note_onehot !== 10'd0) begin n_fail++; $display("FAIL rst_onehot: got %0d expected 0", note_onehot); end
    n_chk++; if (note_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0d expected 0", note_valid); end
    n_chk++; if (period !== 20'd0) begin n_fail++; $display("FAIL rst_period: got %0d expected 0", period); end
    n_chk++; if (peak_level !== 31'd0) begin n_fail++; $display("FAIL rst_peak: got %0d expected 0", peak_level); end
    reset = 1'b0;
    #1;
    n_chk++; if (read_audio_in !== 1'b1) begin n_fail++; $display("FAIL rst_read_release: got %0d expected 1", read_audio_in); end
    avail = 1'b0;
    armed = 1'b0;
    last_rise_rd = -1;
  endtask

  task automatic test_below_hyst();
    int b;
    do_reset();
    wave(56818, 500000, 200, 1, b);
    n_chk++; if (period !== 20'd0) begin n_fail++; $display("FAIL lowamp_period: got %0d expected 0", period); end
    n_chk++; if (peak_level !== 31'd0) begin n_fail++; $display("FAIL lowamp_peak: got %0d expected 0", peak_level); end
    n_chk++; if (note_valid !== 1'b0) begin n_fail++; $display("FAIL lowamp_valid: got %0d expected 0", note_valid); end
    n_chk++; if (note_onehot !== 10'd0) begin n_fail++; $display("FAIL lowamp_onehot: got %0d expected 0", note_onehot); end
  endtask

  task automatic test_a4_lock();
    int b;
    do_reset();
    repeat (60) read_sample(32'd0);
    wave(56818, 2000000, 700, 5, b);
    n_chk++; if (r_period[b] !== 20'd177141) begin n_fail++; $display("FAIL a4_first_period: got %0d expected 177141", r_period[b]); end
    n_chk++; if (r_period[b+1] !== 20'(r_expp[b+1])) begin n_fail++; $display("FAIL a4_period2: got %0d expected %0d", r_period[b+1], r_expp[b+1]); end
    n_chk++; if (r_valid2[b+3] !== 1'b0) begin n_fail++; $display("FAIL a4_early_valid: got %0d expected 0", r_valid2[b+3]); end
    n_chk++; if (r_valid2[b+4] !== 1'b1) begin n_fail++; $display("FAIL a4_valid: got %0d expected 1", r_valid2[b+4]); end
    n_chk++; if (r_onehot[b+4] !== 10'd32) begin n_fail++; $display("FAIL a4_onehot: got %0d expected 32", r_onehot[b+4]); end
    n_chk++; if ((r_period[b+4] < 20'd112536) || (r_period[b+4] > 20'd114620) || (r_period[b+4] !== 20'(r_expp[b+4])))
      begin n_fail++; $display("FAIL a4_period: got %0d expected %0d", r_period[b+4], r_expp[b+4]); end
    n_chk++; if (r_peak[b+4] !== 31'd2000000) begin n_fail++; $display("FAIL a4_peak: got %0d expected 2000000", r_peak[b+4]); end
  endtask

  task automatic test_note_change();
    int b;
    wave(95554, 2000000, 800, 4, b);
    n_chk++; if (r_period[b] !== 20'd192770) begin n_fail++; $display("FAIL c4_first_period: got %0d expected 192770", r_period[b]); end
    n_chk++; if (r_valid1[b] !== 1'b1) begin n_fail++; $display("FAIL c4_valid_hold: got %0d expected 1", r_valid1[b]); end
    n_chk++; if (r_valid2[b] !== 1'b0) begin n_fail++; $display("FAIL c4_valid_drop: got %0d expected 0", r_valid2[b]); end
    n_chk++; if (r_valid2[b+2] !== 1'b0) begin n_fail++; $display("FAIL c4_early_valid: got %0d expected 0", r_valid2[b+2]); end
    n_chk++; if (r_valid2[b+3] !== 1'b1) begin n_fail++; $display("FAIL c4_valid: got %0d expected 1", r_valid2[b+3]); end
    n_chk++; if (r_onehot[b+3] !== 10'd1) begin n_fail++; $display("FAIL c4_onehot: got %0d expected 1", r_onehot[b+3]); end
    n_chk++; if (r_period[b+3] !== 20'(r_expp[b+3])) begin n_fail++; $display("FAIL c4_period: got %0d expected %0d", r_period[b+3], r_expp[b+3]); end
  endtask

  task automatic test_silence();
    int b;
    wave(37923, 2000000, 400, 4, b);
    n_chk++; if (r_period[b] !== 20'd77108) begin n_fail++; $display("FAIL e5_first_period: got %0d expected 77108", r_period[b]); end
    n_chk++; if (r_valid2[b] !== 1'b0) begin n_fail++; $display("FAIL e5_valid_drop: got %0d expected 0", r_valid2[b]); end
    n_chk++; if (r_valid2[b+3] !== 1'b1) begin n_fail++; $display("FAIL e5_valid: got %0d expected 1", r_valid2[b+3]); end
    n_chk++; if (r_onehot[b+3] !== 10'd512) begin n_fail++; $display("FAIL e5_onehot: got %0d expected 512", r_onehot[b+3]); end
    repeat (192) read_sample(32'd0);
    repeat (895) @(posedge CLOCK_50);
    #1;
    n_chk++; if (note_valid !== 1'b1) begin n_fail++; $display("FAIL sil_early_valid: got %0d expected 1", note_valid); end
    n_chk++; if (note_onehot !== 10'd512) begin n_fail++; $display("FAIL sil_early_onehot: got %0d expected 512", note_onehot); end
    @(posedge CLOCK_50);
    #1;
    n_chk++; if (note_valid !== 1'b0) begin n_fail++; $display("FAIL sil_valid: got %0d expected 0", note_valid); end
    n_chk++; if (note_onehot !== 10'd0) begin n_fail++; $display("FAIL sil_onehot: got %0d expected 0", note_onehot); end
    n_chk++; if (period !== 20'(r_expp[b+3])) begin n_fail++; $display("FAIL sil_period_hold: got %0d expected %0d", period, r_expp[b+3]); end
    n_chk++; if (peak_level !== 31'd2000000) begin n_fail++; $display("FAIL sil_peak_hold: got %0d expected 2000000", peak_level); end
  endtask

  task automatic test_sat_reset();
    int b;
    read_sample(-32'sd2000000);
    read_sample(32'h8000_0000);
    b = rise_n;
    read_sample(32'd2000000);
    n_chk++; if (r_peak[b] !== 31'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_peak: got %0h expected 7fffffff", r_peak[b]); end
    n_chk++; if (r_period[b] !== 20'd204086) begin n_fail++; $display("FAIL sat_long_period: got %0d expected 204086", r_period[b]); end
    read_sample(-32'sd2000000);
    read_sample(32'h8000_0000);
    do_reset();
    n_chk++; if (period !== 20'd0) begin n_fail++; $display("FAIL mid_rst_period: got %0d expected 0", period); end
    n_chk++; if (peak_level !== 31'd0) begin n_fail++; $display("FAIL mid_rst_peak: got %0d expected 0", peak_level); end
    read_sample(32'd2000000);
    n_chk++; if (g_p1 !== 20'd0) begin n_fail++; $display("FAIL mid_rst_fsm: got %0d expected 0", g_p1); end
    read_sample(-32'sd2000000);
    b = rise_n;
    read_sample(32'd2000000);
    n_chk++; if (r_period[b] !== 20'd2085) begin n_fail++; $display("FAIL mid_rst_period_new: got %0d expected 2085", r_period[b]); end
    n_chk++; if (r_peak[b] !== 31'd2000000) begin n_fail++; $display("FAIL mid_rst_peak_new: got %0d expected 2000000", r_peak[b]); end
  endtask

  initial begin
    test_reset();
    test_below_hyst();
    test_a4_lock();
    test_note_change();
    test_silence();
    test_sat_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
